// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simon_pkg
//  Description : Shared types and helpers for the memory-game sequence engine.
//                State encoding, level counter width and the 2-bit to one-hot
//                LED decode used for both playback and press matching.
//  Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

    localparam int LEVEL_W = 5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        PLAY_ON  = 3'd2,
        PLAY_OFF = 3'd3,
        INPUT    = 3'd4,
        WIN      = 3'd5,
        LOSE     = 3'd6
    } state_t;

    function automatic logic [3:0] led_decode(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_seq_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_core_if
//  Description : Game-side signal bundle of the sequence engine.
//                i_Start  - restart pulse         i_Rand  - LFSR value
//                i_Btn    - button press pulses   o_Led   - one-hot LED drive
//                o_Busy   - extend/playback       o_Win   - game won
//                o_Lose   - game lost             o_Level - sequence length
//                master drives the inputs, slave is the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
interface simon_seq_core_if;
    import simon_pkg::*;

    logic               i_Start;
    logic [3:0]         i_Rand;
    logic [3:0]         i_Btn;
    logic [3:0]         o_Led;
    logic               o_Busy;
    logic               o_Win;
    logic               o_Lose;
    logic [LEVEL_W-1:0] o_Level;

    modport master (
        output i_Start, i_Rand, i_Btn,
        input  o_Led, o_Busy, o_Win, o_Lose, o_Level
    );

    modport slave (
        input  i_Start, i_Rand, i_Btn,
        output o_Led, o_Busy, o_Win, o_Lose, o_Level
    );

endinterface
`default_nettype wire

// File: rtl/simon_seq_core_step_timer.sv
`default_nettype none
// ============================================================================
//  Module      : step_timer
//  Description : Free-running phase timer for LED playback. o_Done pulses for
//                one cycle every CLKS_PER_STEP cycles counted from the last
//                cycle in which i_Clear was high.
//                i_Clk   - clock            i_Rst  - sync active-high reset
//                i_Clear - restart count    o_Done - phase-complete pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
    parameter int CLKS_PER_STEP = 12_500_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clear,
    output logic o_Done
);

    localparam int                 c_CNT_W = $clog2(CLKS_PER_STEP);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLKS_PER_STEP - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Wraps on its own so back-to-back phases need no explicit clear.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Clear) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_Done = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/simon_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : simon_seq_core
//  Description : Memory-game sequence engine. Each round appends one LFSR
//                sample to the stored sequence, plays the whole sequence on
//                the LEDs, then checks the player's presses against it.
//                i_Clk - clock    i_Rst - sync active-high reset
//                bus   - game-side signals (start, rand, buttons, LEDs,
//                        busy/win/lose flags, level)
//  Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_core #(
    parameter int MAX_LEN       = 16,
    parameter int CLKS_PER_STEP = 12_500_000
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    simon_seq_core_if.slave  bus
);

    import simon_pkg::*;

    localparam int                 c_IDX_W   = $clog2(MAX_LEN);
    localparam logic [LEVEL_W-1:0] c_LEN_ONE = LEVEL_W'(1);
    localparam logic [LEVEL_W-1:0] c_MAX_LEN = LEVEL_W'(MAX_LEN);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE = c_IDX_W'(1);

    state_t             r_state;
    logic [1:0]         r_seq [MAX_LEN];
    logic [LEVEL_W-1:0] r_len;
    logic [c_IDX_W-1:0] r_idx;
    logic [3:0]         r_led;
    logic               r_busy;
    logic               r_win;
    logic               r_lose;

    logic               w_step_done;
    logic               w_clear;
    logic               w_last;
    logic [1:0]         w_cur;
    logic [c_IDX_W-1:0] w_idx_next;
    logic               w_unused;

    // Timer runs only while playing; held cleared otherwise so the first
    // ON phase after ADD is a full step long.
    assign w_clear    = (r_state != PLAY_ON) && (r_state != PLAY_OFF);
    assign w_cur      = r_seq[r_idx];
    assign w_idx_next = r_idx + c_IDX_ONE;
    assign w_last     = (LEVEL_W'(r_idx) == (r_len - c_LEN_ONE));
    assign w_unused   = &{1'b0, bus.i_Rand[3:2]};

    step_timer #(
        .CLKS_PER_STEP (CLKS_PER_STEP)
    ) u_step_timer (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Clear (w_clear),
        .o_Done  (w_step_done)
    );

    // Outputs are registered alongside the state: every transition loads
    // the values that belong to the destination state.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_idx   <= '0;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, WIN, LOSE: begin
                    if (bus.i_Start) begin
                        r_state <= ADD;
                        r_len   <= '0;
                        r_busy  <= 1'b1;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                    end
                end
                ADD: begin
                    r_seq[r_len[c_IDX_W-1:0]] <= bus.i_Rand[1:0];
                    r_len   <= r_len + c_LEN_ONE;
                    r_idx   <= '0;
                    r_state <= PLAY_ON;
                    // seq[0] is being written this very edge on round one.
                    r_led   <= led_decode((r_len == '0) ? bus.i_Rand[1:0] : r_seq[0]);
                end
                PLAY_ON: begin
                    if (w_step_done) begin
                        r_state <= PLAY_OFF;
                        r_led   <= '0;
                    end
                end
                PLAY_OFF: begin
                    if (w_step_done) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= INPUT;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= w_idx_next;
                            r_state <= PLAY_ON;
                            r_led   <= led_decode(r_seq[w_idx_next]);
                        end
                    end
                end
                INPUT: begin
                    // A non-one-hot press can never equal the decoded LED,
                    // so a single compare covers both losing cases.
                    if (bus.i_Btn != 4'b0000) begin
                        if (bus.i_Btn != led_decode(w_cur)) begin
                            r_state <= LOSE;
                            r_lose  <= 1'b1;
                        end else if (!w_last) begin
                            r_idx <= w_idx_next;
                        end else if (r_len == c_MAX_LEN) begin
                            r_state <= WIN;
                            r_win   <= 1'b1;
                        end else begin
                            r_state <= ADD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Led   = r_led;
    assign bus.o_Busy  = r_busy;
    assign bus.o_Win   = r_win;
    assign bus.o_Lose  = r_lose;
    assign bus.o_Level = r_len;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simon_seq_core
//  Description : Self-checking bench for simon_seq_core (MAX_LEN=3,
//                CLKS_PER_STEP=4). The expected LED trace and game outcome
//                are derived from a queue holding the sequence as the game
//                rules define it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_seq_core;

    localparam int c_CPS = 4;
    localparam int c_MAX = 3;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] btn;
        logic       exp_lose;
        logic       exp_busy;
        logic [4:0] exp_level;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] q [$];
    vec_t vecs [8];

    always #5 clk = ~clk;

    simon_seq_core_if bus ();

    simon_seq_core #(
        .MAX_LEN       (c_MAX),
        .CLKS_PER_STEP (c_CPS)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk(name, {bus.o_Led, bus.o_Busy, bus.o_Win, bus.o_Lose, bus.o_Level}, 0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset_outputs");
    endtask

    // Precondition: engine in IDLE, WIN or LOSE.
    task automatic start_game();
        q.delete();
        bus.i_Start = 1'b1;
        bus.i_Rand  = 4'($urandom);
        step();
        bus.i_Start = 1'b0;
        chk("add_busy", bus.o_Busy, 1);
        chk("add_level", bus.o_Level, 0);
        chk("add_flags", {bus.o_Win, bus.o_Lose, bus.o_Led}, 0);
    endtask

    // Called while the engine is in ADD; rv is what ADD samples.
    task automatic play_round(input logic [3:0] rv, input bit noise);
        int         len_v;
        int         k;
        int         ph;
        logic [3:0] exp_led;
        bus.i_Rand = rv;
        q.push_back(rv[1:0]);
        len_v = q.size();
        for (int c = 0; c < 2 * c_CPS * len_v; c++) begin
            step();
            bus.i_Rand  = 4'($urandom);
            bus.i_Start = 1'b0;
            bus.i_Btn   = 4'b0000;
            k  = c / (2 * c_CPS);
            ph = c % (2 * c_CPS);
            exp_led = (ph < c_CPS) ? (4'b0001 << q[k]) : 4'b0000;
            chk("play_led", bus.o_Led, exp_led);
            chk("play_busy", bus.o_Busy, 1);
            chk("play_level", bus.o_Level, len_v);
            chk("play_flags", {bus.o_Win, bus.o_Lose}, 0);
            if (noise && ph == 1)         bus.i_Start = 1'b1;
            if (noise && ph == c_CPS + 1) bus.i_Btn   = 4'($urandom_range(1, 15));
        end
        bus.i_Start = 1'b0;
        bus.i_Btn   = 4'b0000;
        step();
        chk("input_entry", {bus.o_Led, bus.o_Busy, bus.o_Win, bus.o_Lose}, 0);
        chk("input_level", bus.o_Level, len_v);
    endtask

    task automatic play_game(input bit noise, input bit allow_wrong);
        logic [3:0] corr;
        logic [3:0] b;
        start_game();
        for (int lv = 1; lv <= c_MAX; lv++) begin
            play_round(4'($urandom), noise);
            for (int k = 0; k < lv; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    chk("input_idle", {bus.o_Led, bus.o_Busy, bus.o_Win, bus.o_Lose}, 0);
                end
                corr = 4'b0001 << q[k];
                b    = corr;
                if (allow_wrong && $urandom_range(0, 4) == 0) begin
                    b = 4'($urandom_range(1, 15));
                    if (b == corr) b = b ^ 4'b0101;
                end
                bus.i_Btn   = b;
                bus.i_Start = (k == 0);
                step();
                bus.i_Btn   = 4'b0000;
                bus.i_Start = 1'b0;
                if (b != corr) begin
                    chk("lose_flag", bus.o_Lose, 1);
                    chk("lose_other", {bus.o_Win, bus.o_Busy, bus.o_Led}, 0);
                    chk("lose_level", bus.o_Level, lv);
                    repeat (3) begin
                        bus.i_Btn = corr;
                        step();
                        bus.i_Btn = 4'b0000;
                        chk("lose_hold", {bus.o_Lose, bus.o_Busy, bus.o_Win}, 3'b100);
                    end
                    return;
                end else if (k < lv - 1) begin
                    chk("input_next", {bus.o_Led, bus.o_Busy, bus.o_Win, bus.o_Lose}, 0);
                end else if (lv == c_MAX) begin
                    chk("win_flag", {bus.o_Win, bus.o_Lose, bus.o_Busy}, 3'b100);
                    chk("win_level", bus.o_Level, c_MAX);
                    repeat (3) begin
                        bus.i_Btn = 4'($urandom_range(1, 15));
                        step();
                        bus.i_Btn = 4'b0000;
                        chk("win_hold", {bus.o_Win, bus.o_Lose, bus.o_Busy, bus.o_Led}, 7'b1000000);
                        chk("win_hold_level", bus.o_Level, c_MAX);
                    end
                    return;
                end else begin
                    chk("round_add", {bus.o_Busy, bus.o_Win, bus.o_Lose, bus.o_Led}, 7'b1000000);
                    chk("round_add_level", bus.o_Level, lv);
                end
            end
        end
    endtask

    initial begin
        logic [3:0] wrong_btn;
        rst         = 1'b1;
        bus.i_Start = 1'b0;
        bus.i_Btn   = 4'b0000;
        bus.i_Rand  = 4'b0000;
        step();
        step();
        rst = 1'b0;
        chk_idle("power_on_reset");

        //              rand     press    lose  busy  level
        vecs[0] = '{4'b1110, 4'b0100, 1'b0, 1'b1, 5'd1};
        vecs[1] = '{4'b0000, 4'b0001, 1'b0, 1'b1, 5'd1};
        vecs[2] = '{4'b0011, 4'b1000, 1'b0, 1'b1, 5'd1};
        vecs[3] = '{4'b1101, 4'b0010, 1'b0, 1'b1, 5'd1};
        vecs[4] = '{4'b0001, 4'b0100, 1'b1, 1'b0, 5'd1};
        vecs[5] = '{4'b0010, 4'b0011, 1'b1, 1'b0, 5'd1};
        vecs[6] = '{4'b0011, 4'b1111, 1'b1, 1'b0, 5'd1};
        vecs[7] = '{4'b0000, 4'b1001, 1'b1, 1'b0, 5'd1};

        for (int i = 0; i < 8; i++) begin
            reset_dut();
            start_game();
            play_round(vecs[i].rv, 1'b0);
            bus.i_Btn = vecs[i].btn;
            step();
            bus.i_Btn = 4'b0000;
            chk("vec_lose", bus.o_Lose, vecs[i].exp_lose);
            chk("vec_busy", bus.o_Busy, vecs[i].exp_busy);
            chk("vec_level", bus.o_Level, vecs[i].exp_level);
            chk("vec_win", bus.o_Win, 0);
        end

        // Reset in the middle of playback, then presses must do nothing.
        reset_dut();
        start_game();
        bus.i_Rand = 4'b0011;
        step();
        step();
        chk("midrst_led_before", bus.o_Led, 4'b1000);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_idle("midrst_outputs");
        bus.i_Btn = 4'b1000;
        step();
        bus.i_Btn = 4'b0000;
        chk_idle("midrst_btn_ignored");
        step();
        chk_idle("midrst_still_idle");

        // Full game with start/button noise during playback and a start
        // coinciding with the first press of each round.
        reset_dut();
        play_game(1'b1, 1'b0);

        // Restart from WIN, then a deliberate wrong press, then restart from LOSE.
        start_game();
        play_round(4'($urandom), 1'b0);
        wrong_btn = (4'b0001 << q[0]) ^ 4'b0011;
        bus.i_Btn = wrong_btn;
        step();
        bus.i_Btn = 4'b0000;
        chk("wrong_lose", {bus.o_Lose, bus.o_Win, bus.o_Busy}, 3'b100);
        step();
        chk("wrong_lose_hold", bus.o_Lose, 1);
        start_game();
        play_round(4'($urandom), 1'b0);

        for (int g = 0; g < 6; g++) begin
            reset_dut();
            play_game(g[0], 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
